// File: rtl/instr_fetch.sv
// Instruction fetch/sequencing stage: walks the program ROM, fetches MVI immediates,
// and hands each instruction to the control FSM as an IR word plus a Run window.
module instr_fetch #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned IR_W   = 9
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iStart,
  input  logic              iStop,
  input  logic              iDone,
  output logic [ADDR_W-1:0] oAddr,
  input  logic [IR_W-1:0]   iData,
  output logic [IR_W-1:0]   oIR,
  output logic [IR_W-1:0]   oDin,
  output logic              oRun,
  output logic [ADDR_W-1:0] oPC,
  output logic              oBusy,
  output logic              oHalt
);

  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    IDLE, FETCH, CAPT, IFETCH, ICAPT, EXEC, GAP, HALT
  } stateT;

  stateT             state, nextState;
  logic [ADDR_W-1:0] pc, pcNext;
  logic [IR_W-1:0]   irNext, dinNext;
  logic              stopPend, stopPendNext;
  logic              runNext, haltNext, busyNext;
  logic [2:0]        opcode;

  assign opcode = iData[IR_W-1 -: 3];
  assign oAddr  = pc;
  assign oPC    = pc;

  // State register
  always_ff @(posedge iClk) begin
    if (!iRst_n) state <= IDLE;
    else         state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (iStart) nextState = FETCH;
      FETCH:   nextState = CAPT;
      CAPT: begin
        if (opcode == OP_HALT)     nextState = HALT;
        else if (opcode == OP_MVI) nextState = IFETCH;
        else                       nextState = EXEC;
      end
      IFETCH:  nextState = ICAPT;
      ICAPT:   nextState = EXEC;
      EXEC:    if (iDone) nextState = GAP;
      GAP:     nextState = stopPend ? IDLE : FETCH;
      HALT:    if (iStart) nextState = FETCH;
      default: nextState = IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    pcNext       = pc;
    irNext       = oIR;
    dinNext      = oDin;
    stopPendNext = stopPend;
    if (iStop && state != IDLE) stopPendNext = 1'b1;
    case (state)
      IDLE: begin
        if (iStart) begin
          pcNext       = '0;
          stopPendNext = 1'b0;
        end
      end
      CAPT: begin
        if (opcode != OP_HALT) begin
          irNext = iData;
          pcNext = pc + ADDR_W'(1);
        end
      end
      ICAPT: begin
        dinNext = iData;
        pcNext  = pc + ADDR_W'(1);
      end
      GAP: begin
        if (stopPend) stopPendNext = 1'b0;
      end
      HALT: begin
        // Start beats a simultaneous stop
        if (iStart) begin
          pcNext       = '0;
          stopPendNext = 1'b0;
        end
      end
      default: ;
    endcase
    runNext  = (nextState == EXEC);
    haltNext = (nextState == HALT);
    busyNext = (nextState != IDLE) && (nextState != HALT);
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      pc       <= '0;
      oIR      <= '0;
      oDin     <= '0;
      stopPend <= 1'b0;
      oRun     <= 1'b0;
      oHalt    <= 1'b0;
      oBusy    <= 1'b0;
    end else begin
      pc       <= pcNext;
      oIR      <= irNext;
      oDin     <= dinNext;
      stopPend <= stopPendNext;
      oRun     <= runNext;
      oHalt    <= haltNext;
      oBusy    <= busyNext;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboarded bench for instr_fetch: a ROM model, an auto-responding Done source,
// and a monitor that pops the expected IR/DIN pair at every Run rising edge.
module tb_instr_fetch;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned IR_W   = 9;

  logic              iClk = 1'b0, iRst_n = 1'b0, iStart = 1'b0, iStop = 1'b0, iDone = 1'b0;
  logic [ADDR_W-1:0] oAddr, oPC;
  logic [IR_W-1:0]   iData = '0, oIR, oDin;
  logic              oRun, oBusy, oHalt;

  logic [IR_W-1:0] rom [32];
  int checks = 0, errors = 0, cyc = 0, doneDelay = 0, runCnt = 0;

  typedef struct packed {
    logic [IR_W-1:0] ir;
    logic [IR_W-1:0] din;
  } expT;
  expT             expQ[$];
  int              riseCyc[$];
  logic            prevRun = 1'b0;
  logic [IR_W-1:0] modelDin = '0;
  logic [2:0]      ops [6] = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110};

  instr_fetch #(.ADDR_W(ADDR_W), .IR_W(IR_W)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iStop(iStop), .iDone(iDone),
    .oAddr(oAddr), .iData(iData), .oIR(oIR), .oDin(oDin), .oRun(oRun),
    .oPC(oPC), .oBusy(oBusy), .oHalt(oHalt)
  );

  always #5 iClk = ~iClk;

  // Synchronous ROM: data valid the cycle after the address
  always @(posedge iClk) begin
    cyc   <= cyc + 1;
    iData <= rom[oAddr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Control-FSM stand-in: raise Done once Run has been high doneDelay cycles (0 = never)
  always @(negedge iClk) begin
    if (oRun !== 1'b1) begin
      runCnt = 0;
      iDone  = 1'b0;
    end else begin
      runCnt++;
      iDone = (doneDelay != 0) && (runCnt >= doneDelay);
    end
  end

  // Scoreboard: every Run rising edge must match the next expected issue
  always @(negedge iClk) begin
    if (oRun === 1'b1 && prevRun !== 1'b1) begin
      riseCyc.push_back(cyc);
      check("issue_pending", 32'(expQ.size() > 0), 32'(1));
      if (expQ.size() > 0) begin
        expT e;
        e = expQ.pop_front();
        check("sb_ir", 32'(oIR), 32'(e.ir));
        check("sb_din", 32'(oDin), 32'(e.din));
      end
    end
    prevRun = oRun;
  end

  task automatic pushInstr(input logic [IR_W-1:0] w);
    expQ.push_back('{ir: w, din: modelDin});
  endtask

  task automatic pushMvi(input logic [IR_W-1:0] w, input logic [IR_W-1:0] imm);
    modelDin = imm;
    expQ.push_back('{ir: w, din: imm});
  endtask

  task automatic pulseStart(input logic withStop);
    @(negedge iClk);
    iStart = 1'b1;
    iStop  = withStop;
    @(negedge iClk);
    iStart = 1'b0;
    iStop  = 1'b0;
  endtask

  // sel: 0=oRun 1=oHalt 2=oBusy; n = negedges waited
  task automatic waitSig(input int sel, input logic lvl, input int budget, output int n);
    logic v;
    n = 0;
    do begin
      @(negedge iClk);
      n++;
      v = (sel == 0) ? oRun : (sel == 1) ? oHalt : oBusy;
    end while (v !== lvl && n < budget);
    if (v !== lvl) check($sformatf("timeout_sel%0d", sel), 32'(v), 32'(lvl));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n, hold, base;
    foreach (rom[i]) rom[i] = '0;
    repeat (3) @(negedge iClk);
    iRst_n = 1'b1;
    check("rst_run", 32'(oRun), 32'(0));
    check("rst_busy", 32'(oBusy), 32'(0));
    check("rst_halt", 32'(oHalt), 32'(0));
    check("rst_pc", 32'(oPC), 32'(0));
    check("rst_ir", 32'(oIR), 32'(0));
    check("rst_din", 32'(oDin), 32'(0));

    // MV then HALT
    rom[0] = 9'o012; rom[1] = 9'o700;
    doneDelay = 1;
    pushInstr(9'o012);
    pulseStart(1'b0);
    waitSig(0, 1'b1, 10, n);
    check("lat_mv", 32'(n), 32'(2));
    waitSig(0, 1'b0, 5, n);
    check("run_width", 32'(n), 32'(1));
    waitSig(1, 1'b1, 10, n);
    check("halt_pc", 32'(oPC), 32'(1));
    check("halt_run", 32'(oRun), 32'(0));
    check("halt_busy", 32'(oBusy), 32'(0));
    check("halt_ir", 32'(oIR), 32'(9'o012));

    // MVI then HALT, restarted from HALT
    rom[0] = 9'o130; rom[1] = 9'h05A; rom[2] = 9'o700;
    pushMvi(9'o130, 9'h05A);
    pulseStart(1'b0);
    check("restart_halt_clr", 32'(oHalt), 32'(0));
    waitSig(0, 1'b1, 10, n);
    check("lat_mvi", 32'(n), 32'(4));
    waitSig(0, 1'b0, 5, n);
    check("mvi_next_addr", 32'(oAddr), 32'(2));
    waitSig(1, 1'b1, 10, n);
    check("mvi_halt_pc", 32'(oPC), 32'(2));
    check("mvi_halt_din", 32'(oDin), 32'(9'h05A));

    // Long EXEC with stop request mid-instruction
    rom[0] = 9'o200; rom[1] = 9'o300;
    doneDelay = 0;
    pushInstr(9'o200);
    pulseStart(1'b0);
    waitSig(0, 1'b1, 10, n);
    hold = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge iClk);
      iStop = (i == 5);
      if (oRun === 1'b1) hold++;
    end
    iStop = 1'b0;
    check("run_hold", 32'(hold), 32'(20));
    doneDelay = 1;
    waitSig(0, 1'b0, 5, n);
    waitSig(2, 1'b0, 5, n);
    check("gap_to_idle", 32'(n), 32'(1));
    hold = 0;
    repeat (10) begin
      @(negedge iClk);
      if (oRun === 1'b1 || oBusy === 1'b1 || oHalt === 1'b1) hold++;
    end
    check("idle_quiet", 32'(hold), 32'(0));
    check("idle_pc", 32'(oPC), 32'(1));

    // Run up to an MVI at 30 whose immediate sits at 31; PC wraps to 0
    for (int i = 0; i < 30; i++) begin
      rom[i] = {ops[i % 6], 6'(i)};
      pushInstr(rom[i]);
    end
    rom[30] = 9'o150; rom[31] = 9'h1A5;
    pushMvi(9'o150, 9'h1A5);
    pulseStart(1'b0);
    waitSig(0, 1'b1, 10, n);
    rom[0] = 9'o700;
    waitSig(1, 1'b1, 400, n);
    check("wrap_pc", 32'(oPC), 32'(0));
    check("wrap_din", 32'(oDin), 32'(9'h1A5));
    check("wrap_ir", 32'(oIR), 32'(9'o150));

    // Start and stop together in HALT: start wins, execution continues
    rom[0] = 9'o200; rom[1] = 9'o310; rom[2] = 9'o700;
    pushInstr(9'o200);
    pushInstr(9'o310);
    base = riseCyc.size();
    pulseStart(1'b1);
    waitSig(1, 1'b1, 50, n);
    check("ss_pc", 32'(oPC), 32'(2));
    check("ss_rises", 32'(riseCyc.size() - base), 32'(2));
    if (riseCyc.size() >= base + 2)
      check("ss_period", 32'(riseCyc[base+1] - riseCyc[base]), 32'(4));

    // Reset in the middle of EXEC
    rom[0] = 9'o200;
    pushInstr(9'o200);
    doneDelay = 0;
    pulseStart(1'b0);
    waitSig(0, 1'b1, 10, n);
    @(negedge iClk);
    iRst_n = 1'b0;
    @(negedge iClk);
    iRst_n = 1'b1;
    check("mrst_run", 32'(oRun), 32'(0));
    check("mrst_pc", 32'(oPC), 32'(0));
    check("mrst_ir", 32'(oIR), 32'(0));
    check("mrst_din", 32'(oDin), 32'(0));
    check("mrst_busy", 32'(oBusy), 32'(0));
    check("mrst_halt", 32'(oHalt), 32'(0));
    repeat (5) @(negedge iClk);
    check("mrst_stays_idle", 32'(oBusy), 32'(0));
    check("queue_empty", 32'(expQ.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch and sequencing stage that sits directly upstream of the processor control FSM.
- Holds the program counter and reads 9-bit instruction words from a synchronous program ROM.
- For MVI it also fetches the following immediate word, and presents it on the DIN path.
- Drives the FSM's IR word and Run level, then waits for Done before fetching the next instruction.

Parameters:
ADDR_W, 5, program ROM address width; PC wraps modulo 2^ADDR_W
IR_W, 9, instruction and immediate word width; opcode = bits [IR_W-1:IR_W-3]

Ports:
iClk  in  1  clock, rising edge
iRst_n  in  1  synchronous active-low reset
iStart  in  1  begin execution at address 0; honoured only in IDLE or HALT
iStop  in  1  stop request; level sampled every cycle and latched
iDone  in  1  instruction-complete pulse from the control FSM
oAddr  out  ADDR_W  ROM address; combinationally equals PC
iData  in  IR_W  ROM read data; valid the cycle after oAddr is presented
oIR  out  IR_W  registered instruction word to the control FSM
oDin  out  IR_W  registered immediate word (DIN bus)
oRun  out  1  registered; high for the whole execute window
oPC  out  ADDR_W  current PC, for debug
oBusy  out  1  high in every state except IDLE and HALT
oHalt  out  1  high in HALT

Behaviour:
- Reset (iRst_n=0 at a rising edge): state=IDLE, PC=0, oIR=0, oDin=0, oRun=0, stop_pend=0, oHalt=0, oBusy=0. This applies from any state, including mid-EXEC.
- Opcodes: 000 MV, 001 MVI, 010 ADD, 011 SUB, 111 HALT.
  - HALT is consumed here and never issued to the FSM.
  - Opcodes 100..110 are issued as normal instructions without an immediate.
- States: IDLE, FETCH, CAPT, IFETCH, ICAPT, EXEC, GAP, HALT.
- IDLE:
  - On iStart=1: PC<=0, stop_pend<=0, go to FETCH.
- FETCH:
  - oAddr=PC; go to CAPT unconditionally.
- CAPT (iData holds the word at PC):
  - If opcode=111: go to HALT; oIR and PC are unchanged.
  - Otherwise: oIR<=iData and PC<=PC+1.
  - Then go to IFETCH if opcode=001, else to EXEC.
- IFETCH:
  - oAddr=PC (the immediate address); go to ICAPT.
- ICAPT:
  - oDin<=iData, PC<=PC+1, go to EXEC.
- EXEC:
  - oRun=1 throughout.
  - Stays in EXEC until iDone=1 is sampled, then goes to GAP.
  - No timeout; iStop does not abort an instruction in progress.
- GAP:
  - oRun=0 for exactly one cycle, so Run has a low edge between instructions.
  - If stop_pend=1: go to IDLE and clear stop_pend. Otherwise go to FETCH.
- HALT:
  - oHalt=1, oRun=0.
  - On iStart=1: PC<=0, oHalt<=0, go to FETCH.
- oRun is registered:
  - It rises on the edge that enters EXEC. On that same edge oIR/oDin are final, so the IR is stable before and throughout Run.
  - It falls on the edge that enters GAP.
- Latency for non-MVI instructions: FETCH→CAPT→EXEC, so oRun rises 2 cycles after entering FETCH.
- Latency for MVI: 4 cycles after entering FETCH.
- Minimum instruction period: 4 cycles (non-MVI) or 6 cycles (MVI) when iDone arrives the first EXEC cycle.
- stop_pend:
  - Set whenever iStop=1 in any state other than IDLE.
  - Cleared on entry to IDLE, or on iStart.
  - iStop in IDLE is ignored.
- Simultaneous iStart and iStop in IDLE/HALT: start wins and stop_pend is cleared.
- iDone outside EXEC is ignored.
- PC arithmetic: ADDR_W-bit, wraps from 2^ADDR_W-1 to 0, including when the MVI immediate sits at the last address.
- oIR and oDin hold their last values in every state except CAPT/ICAPT loads. oDin is unchanged by non-MVI instructions.

Test Plan:
- Reset mid-EXEC with oRun=1: assert iRst_n=0 for 1 cycle -> next cycle state IDLE, oRun=0, oPC=0, oIR=0, oBusy=0.
- ROM[0]=9'o012 (MV R1,R2), ROM[1]=9'o700; pulse iStart, answer iDone one cycle after oRun rises:
  - oIR=9'o012 when oRun rises, 2 cycles after FETCH.
  - oRun low exactly 1 cycle in GAP.
  - Then HALT: oHalt=1, oPC=1, oRun stays 0.
- ROM[0]=9'o130 (MVI R3), ROM[1]=9'h05A, ROM[2]=9'o700 -> oIR=9'o130, oDin=9'h05A when oRun rises; next fetch address 2; then halt with oPC=2.
- iDone held 0 for 20 cycles in EXEC, with iStop pulsed during EXEC:
  - oRun stays 1 for the full 20 cycles.
  - After iDone: GAP then IDLE; oBusy=0; no further ROM fetch.
- ADDR_W=5, MVI placed at address 30 with its immediate at 31 -> oDin=ROM[31], PC wraps to 0, next instruction fetched from address 0.
- iStart and iStop both asserted in HALT -> restart from address 0; stop_pend=0; execution continues past the first GAP.
